// File: rtl/vga_text_writer.sv
// vga_text_writer
//
// CPU-facing text-mode write port for the VGA character RAM. The CPU writes
// three registers over a 16-bit bus: CURSOR positions the row/column cursor,
// DATA queues one {colour, char} cell at the cursor and advances it, and CTRL
// bit 0 requests a hardware clear-screen. Queued cells drain into the
// character RAM one per cycle. A clear fills every cell with a blank space.
//
// Optional feature (compile-time macro VGA_TEXT_WRITER_NEWLINE_EN):
//   When defined, a DATA write of char 8'h0A queues nothing. It moves the
//   cursor to column 0 of the next row, wrapping from the last row to row 0.
//   When undefined, 8'h0A is an ordinary glyph.
//
// Parameters:
//   COLS        text columns per row (<= 128)
//   ROWS        text rows (<= 128)
//   FIFO_DEPTH  queued character writes (power of two, >= 2)
//
// Ports:
//   clk        system clock, shared with the pixel generator
//   rst        asynchronous active-high reset
//   cpu_wr     write strobe
//   cpu_addr   register select: 0 CURSOR, 1 DATA, 2 CTRL, 3 reserved
//   cpu_wdata  write data
//   cpu_rdata  read data, combinational on cpu_addr
//   cpu_ready  high when a write is accepted this cycle
//   ram_we     character RAM write enable (registered)
//   ram_addr   cell index row*COLS+col (registered)
//   ram_wdata  {colour[2:0], char[7:0]} (registered)
//   dbg_state  current FSM state (0 IDLE, 1 CLEAR)
//
// Handshake: a write transfers on a rising clk edge where cpu_wr=1 and
// cpu_ready=1. cpu_ready does not depend on cpu_wr. While cpu_ready=0 the
// strobe is ignored, and the CPU keeps cpu_wr, cpu_addr and cpu_wdata stable
// until an edge with cpu_ready=1.

module vga_text_writer #(
  parameter int COLS       = 80,
  parameter int ROWS       = 30,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_wr,
  input  logic [1:0]  cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_ready,
  output logic        ram_we,
  output logic [11:0] ram_addr,
  output logic [10:0] ram_wdata,
  output logic        dbg_state
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] REG_CURSOR = 2'd0;
  localparam logic [1:0] REG_DATA   = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  // 8-bit limits so that ROWS or COLS of 128 still compare correctly.
  localparam logic [7:0]  ROWS_L    = 8'(ROWS);
  localparam logic [7:0]  COLS_L    = 8'(COLS);
  localparam logic [6:0]  ROW_LAST  = 7'(ROWS - 1);
  localparam logic [6:0]  COL_LAST  = 7'(COLS - 1);
  localparam logic [11:0] CELL_LAST = 12'(ROWS * COLS - 1);
  localparam logic [10:0] BLANK     = {3'b000, 8'h20};

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t        state, state_next;

  // Cursor and clear request
  logic [6:0]    row, col;
  logic          clear_pending;
  logic          clear_active;
  logic          clear_start;
  logic [11:0]   clear_cnt, clear_cnt_next;

  // Character FIFO: each entry is {cell index, colour, char}
  logic [22:0]   fifo_mem [FIFO_DEPTH];
  logic [22:0]   fifo_head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;
  logic          push, pop;

  logic          accept;
  logic          is_newline;
  logic          cursor_valid;
  logic [11:0]   cursor_cell;

  logic          ram_we_next;
  logic [11:0]   ram_addr_next;
  logic [10:0]   ram_wdata_next;

  // Bit 15 of the bus carries no register field.
  logic          unused_wdata;
  assign unused_wdata = cpu_wdata[15];

  // ---------------------------------------------------------------------
  // Bus side
  // ---------------------------------------------------------------------
  assign clear_active = (state == ST_CLEAR);
  assign fifo_full    = (fifo_count == CW'(FIFO_DEPTH));
  assign fifo_empty   = (fifo_count == '0);
  assign cpu_ready    = !fifo_full && !clear_pending && !clear_active;
  assign accept       = cpu_wr && cpu_ready;
  assign dbg_state    = state;

`ifdef VGA_TEXT_WRITER_NEWLINE_EN
  assign is_newline = (cpu_wdata[7:0] == 8'h0A);
`else
  assign is_newline = 1'b0;
`endif

  assign cursor_valid = ({1'b0, cpu_wdata[14:8]} < ROWS_L) &&
                        ({1'b0, cpu_wdata[6:0]}  < COLS_L);
  assign cursor_cell  = 12'(row) * 12'(COLS) + 12'(col);

  // A newline only moves the cursor, so it never occupies a FIFO slot.
  assign push = accept && (cpu_addr == REG_DATA) && !is_newline;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row           <= '0;
      col           <= '0;
      clear_pending <= 1'b0;
    end else begin
      // The pending flag is handed to the FSM once the queue has drained.
      if (clear_start) begin
        clear_pending <= 1'b0;
      end
      if (accept) begin
        case (cpu_addr)
          REG_CURSOR: begin
            // An out-of-range position is accepted but leaves the cursor alone.
            if (cursor_valid) begin
              row <= cpu_wdata[14:8];
              col <= cpu_wdata[6:0];
            end
          end
          REG_DATA: begin
            if (is_newline || col == COL_LAST) begin
              col <= '0;
              row <= (row == ROW_LAST) ? 7'd0 : row + 7'd1;
            end else begin
              col <= col + 7'd1;
            end
          end
          REG_CTRL: begin
            if (cpu_wdata[0]) begin
              clear_pending <= 1'b1;
              row           <= '0;
              col           <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    cpu_rdata = '0;
    case (cpu_addr)
      REG_CURSOR: cpu_rdata = {1'b0, row, 1'b0, col};
      REG_CTRL:   cpu_rdata = {11'b0, clear_pending | clear_active, 4'(fifo_count)};
      default:    cpu_rdata = '0;
    endcase
  end

  // ---------------------------------------------------------------------
  // Character FIFO
  // ---------------------------------------------------------------------
  // Storage has no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {cursor_cell, cpu_wdata[10:0]};
    end
  end

  assign fifo_head = fifo_mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      // Simultaneous push and pop leave the count unchanged.
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Drain / clear FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      clear_cnt <= '0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      state     <= state_next;
      clear_cnt <= clear_cnt_next;
      ram_we    <= ram_we_next;
      ram_addr  <= ram_addr_next;
      ram_wdata <= ram_wdata_next;
    end
  end

  always_comb begin
    state_next     = state;
    clear_cnt_next = clear_cnt;
    ram_we_next    = 1'b0;
    ram_addr_next  = ram_addr;
    ram_wdata_next = ram_wdata;
    pop            = 1'b0;
    clear_start    = 1'b0;

    case (state)
      ST_IDLE: begin
        // Queued characters always go out before a requested clear starts,
        // so they are written and then overwritten by the clear.
        if (!fifo_empty) begin
          pop            = 1'b1;
          ram_we_next    = 1'b1;
          ram_addr_next  = fifo_head[22:11];
          ram_wdata_next = fifo_head[10:0];
        end else if (clear_pending) begin
          clear_start    = 1'b1;
          clear_cnt_next = '0;
          state_next     = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        ram_we_next    = 1'b1;
        ram_addr_next  = clear_cnt;
        ram_wdata_next = BLANK;
        // Leaving on the edge that registers the last cell re-opens the bus
        // on that same edge.
        if (clear_cnt == CELL_LAST) begin
          state_next = ST_IDLE;
        end else begin
          clear_cnt_next = clear_cnt + 12'd1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_vga_text_writer.sv
module tb_vga_text_writer;

  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int CELLS = COLS * ROWS;
`ifdef VGA_TEXT_WRITER_NEWLINE_EN
  localparam bit NL = 1'b1;
`else
  localparam bit NL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_wr;
  logic [1:0]  cpu_addr;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_ready;
  logic        ram_we;
  logic [11:0] ram_addr;
  logic [10:0] ram_wdata;
  logic        dbg_state;

  int total = 0;
  int bad   = 0;

  // Reference model: cursor as plain integers, expected RAM writes in order.
  int          m_row = 0;
  int          m_col = 0;
  logic [22:0] exp_q[$];

  typedef struct {
    logic [1:0]  addr;
    logic [15:0] wdata;
    logic        exp_we;
    logic [11:0] exp_addr;
    logic [10:0] exp_wdata;
    logic [15:0] exp_cursor;
  } vec_t;

  vec_t vecs[15];

  int run_len;
  bit started, gap, early, done;
  int clears_left;

  vga_text_writer #(.COLS(COLS), .ROWS(ROWS), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_wr    (cpu_wr),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model_cursor();
    return {1'b0, 7'(m_row), 1'b0, 7'(m_col)};
  endfunction

  task automatic model_accept(input logic [1:0] a, input logic [15:0] d);
    int lin;
    case (a)
      2'd0: begin
        if (int'(d[14:8]) < ROWS && int'(d[6:0]) < COLS) begin
          m_row = int'(d[14:8]);
          m_col = int'(d[6:0]);
        end
      end
      2'd1: begin
        if (NL && d[7:0] == 8'h0A) begin
          m_col = 0;
          m_row = (m_row + 1) % ROWS;
        end else begin
          lin = m_row * COLS + m_col;
          exp_q.push_back({12'(lin), d[10:0]});
          lin   = (lin + 1) % CELLS;
          m_row = lin / COLS;
          m_col = lin % COLS;
        end
      end
      2'd2: begin
        if (d[0]) begin
          m_row = 0;
          m_col = 0;
          for (int i = 0; i < CELLS; i++) exp_q.push_back({12'(i), 11'h020});
        end
      end
      default: ;
    endcase
  endtask

  // Drives one write and holds it until accepted; returns 1 time unit after
  // the accepting edge with cpu_wr released.
  task automatic cpu_write(input logic [1:0] a, input logic [15:0] d);
    int waited;
    waited = 0;
    @(negedge clk);
    cpu_wr = 1'b1;
    cpu_addr = a;
    cpu_wdata = d;
    #1;
    while (!cpu_ready && waited < 5000) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!cpu_ready) begin
      check("write_accept_timeout", 32'(cpu_ready), 32'd1);
      cpu_wr = 1'b0;
    end else begin
      model_accept(a, d);
      @(posedge clk);
      #1;
      cpu_wr = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    check("drain_complete", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!rst && ram_we) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL ram_write: got unexpected write addr=%0d data=%h expected none",
                 ram_addr, ram_wdata);
      end else begin
        logic [22:0] e;
        e = exp_q.pop_front();
        check("ram_write", 32'({ram_addr, ram_wdata}), 32'(e));
      end
    end
  end

  // ---------------- test ----------------
  initial begin
    vecs[0]  = '{2'd1, 16'h0741, 1'b1, 12'd0,    11'h741, 16'h0001};
    vecs[1]  = '{2'd0, 16'h1D4F, 1'b0, 12'd0,    11'h000, 16'h1D4F};
    vecs[2]  = '{2'd1, 16'h0142, 1'b1, 12'd2399, 11'h142, 16'h0000};
    vecs[3]  = '{2'd0, 16'h0305, 1'b0, 12'd0,    11'h000, 16'h0305};
    vecs[4]  = '{2'd0, 16'h1E00, 1'b0, 12'd0,    11'h000, 16'h0305};
    vecs[5]  = '{2'd0, 16'h0050, 1'b0, 12'd0,    11'h000, 16'h0305};
    vecs[6]  = '{2'd1, 16'h04FF, 1'b1, 12'd245,  11'h4FF, 16'h0306};
    vecs[7]  = '{2'd2, 16'h0000, 1'b0, 12'd0,    11'h000, 16'h0306};
    vecs[8]  = '{2'd3, 16'hFFFF, 1'b0, 12'd0,    11'h000, 16'h0306};
    vecs[9]  = '{2'd0, 16'h004F, 1'b0, 12'd0,    11'h000, 16'h004F};
    vecs[10] = '{2'd1, 16'h0233, 1'b1, 12'd79,   11'h233, 16'h0100};
    vecs[11] = '{2'd0, 16'h819D, 1'b0, 12'd0,    11'h000, 16'h011D};
    vecs[12] = '{2'd0, 16'h050A, 1'b0, 12'd0,    11'h000, 16'h050A};
`ifdef VGA_TEXT_WRITER_NEWLINE_EN
    vecs[13] = '{2'd1, 16'h000A, 1'b0, 12'd0,    11'h000, 16'h0600};
    vecs[14] = '{2'd1, 16'hFFC1, 1'b1, 12'd480,  11'h7C1, 16'h0601};
`else
    vecs[13] = '{2'd1, 16'h000A, 1'b1, 12'd410,  11'h00A, 16'h050B};
    vecs[14] = '{2'd1, 16'hFFC1, 1'b1, 12'd411,  11'h7C1, 16'h050C};
`endif

    // reset
    rst = 1'b1;
    cpu_wr = 1'b0;
    cpu_addr = 2'd0;
    cpu_wdata = 16'h0000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_ram_we", 32'(ram_we), 32'd0);
    check("reset_ram_addr", 32'(ram_addr), 32'd0);
    check("reset_ram_wdata", 32'(ram_wdata), 32'd0);
    check("reset_ready", 32'(cpu_ready), 32'd1);
    check("reset_dbg_state", 32'(dbg_state), 32'd0);
    check("reset_cursor", 32'(cpu_rdata), 32'h0);
    cpu_addr = 2'd2;
    #1;
    check("reset_ctrl_status", 32'(cpu_rdata), 32'h0);
    cpu_addr = 2'd3;
    #1;
    check("reset_reserved", 32'(cpu_rdata), 32'h0);

    // table-driven vectors
    for (int i = 0; i < 15; i++) begin
      cpu_write(vecs[i].addr, vecs[i].wdata);
      cpu_addr = 2'd0;
      #1;
      check($sformatf("vec%0d_cursor", i), 32'(cpu_rdata), 32'(vecs[i].exp_cursor));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_ram_we", i), 32'(ram_we), 32'(vecs[i].exp_we));
      if (vecs[i].exp_we) begin
        check($sformatf("vec%0d_ram_addr", i), 32'(ram_addr), 32'(vecs[i].exp_addr));
        check($sformatf("vec%0d_ram_wdata", i), 32'(ram_wdata), 32'(vecs[i].exp_wdata));
      end
    end
    wait_drain();

    // FIFO occupancy readback: one entry right after acceptance, drained next cycle
    cpu_write(2'd1, 16'h0231);
    cpu_addr = 2'd2;
    #1;
    check("fifo_count_one", 32'(cpu_rdata), 32'h0001);
    @(posedge clk);
    #1;
    check("fifo_count_zero", 32'(cpu_rdata), 32'h0000);
    wait_drain();

    // three characters then a clear in consecutive cycles
    cpu_write(2'd0, 16'h0000);
    cpu_write(2'd1, 16'h0161);
    cpu_write(2'd1, 16'h0262);
    cpu_write(2'd1, 16'h0363);
    cpu_write(2'd2, 16'h0001);
    cpu_addr = 2'd2;
    #1;
    check("clear_busy_flag", 32'(cpu_rdata[4]), 32'd1);
    check("clear_ready_low", 32'(cpu_ready), 32'd0);
    wait_drain();

    // clear with a DATA write held on the bus the whole time
    cpu_write(2'd0, 16'h0A0A);
    cpu_write(2'd2, 16'h0001);
    @(negedge clk);
    cpu_wr = 1'b1;
    cpu_addr = 2'd1;
    cpu_wdata = 16'h0555;
    run_len = 0;
    started = 1'b0;
    gap = 1'b0;
    early = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      if (ram_we) begin
        run_len++;
        started = 1'b1;
      end else if (started) begin
        gap = 1'b1;
      end
      if (ram_we && ram_addr == 12'd2399) begin
        done = 1'b1;
        check("clear_ready_on_last", 32'(cpu_ready), 32'd1);
      end else begin
        if (cpu_ready) early = 1'b1;
        @(negedge clk);
      end
    end
    check("clear_finished", 32'(done), 32'd1);
    check("clear_len", 32'(run_len), 32'(CELLS));
    check("clear_no_gap", 32'(gap), 32'd0);
    check("clear_ready_held_low", 32'(early), 32'd0);
    if (done) begin
      model_accept(2'd1, 16'h0555);
      @(posedge clk);
      #1;
    end
    cpu_wr = 1'b0;
    cpu_addr = 2'd0;
    #1;
    check("held_write_cursor", 32'(cpu_rdata), 32'(model_cursor()));
    wait_drain();

    // randomized traffic against the model
    clears_left = 1;
    for (int n = 0; n < 400; n++) begin
      int r;
      logic [1:0]  a;
      logic [15:0] d;
      r = $urandom_range(0, 99);
      if (r < 45) begin
        a = 2'd1;
        d = 16'($urandom);
        if ($urandom_range(0, 9) == 0) d[7:0] = 8'h0A;
      end else if (r < 80) begin
        a = 2'd0;
        d = {1'($urandom), 7'($urandom_range(0, 35)), 1'($urandom), 7'($urandom_range(0, 90))};
      end else if (r < 98 || clears_left == 0) begin
        a = ($urandom_range(0, 1) == 0) ? 2'd2 : 2'd3;
        d = 16'($urandom) & 16'hFFFE;
      end else begin
        a = 2'd2;
        d = 16'h0001;
        clears_left--;
      end
      cpu_write(a, d);
      if ($urandom_range(0, 1) == 0) begin
        cpu_addr = 2'd0;
        #1;
        check("rand_cursor", 32'(cpu_rdata), 32'(model_cursor()));
      end
    end
    wait_drain();

    // reset in the middle of a clear
    cpu_write(2'd2, 16'h0001);
    repeat (100) @(negedge clk);
    check("midclear_we_active", 32'(ram_we), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_we", 32'(ram_we), 32'd0);
    check("async_rst_addr", 32'(ram_addr), 32'd0);
    exp_q.delete();
    m_row = 0;
    m_col = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    cpu_addr = 2'd2;
    #1;
    check("post_rst_status", 32'(cpu_rdata), 32'h0);
    check("post_rst_ready", 32'(cpu_ready), 32'd1);

    // reset with a character still queued
    cpu_write(2'd0, 16'h0203);
    cpu_write(2'd1, 16'h0444);
    rst = 1'b1;
    #1;
    exp_q.delete();
    m_row = 0;
    m_col = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    cpu_addr = 2'd0;
    #1;
    check("post_rst_cursor", 32'(cpu_rdata), 32'h0);
    cpu_write(2'd1, 16'h0341);
    wait_drain();

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_text_writer.md
# vga_text_writer

CPU-facing text-mode write port sitting directly upstream of the VGA pixel generator's character RAM. It accepts 16-bit bus writes, tracks a row/column cursor, and queues character writes in a small FIFO. It drains the FIFO into the character RAM's write port, one cell per cycle, and also provides a hardware clear-screen sequence.

## Interface

Parameters:
- COLS, 80, text columns per row (max 128)
- ROWS, 30, text rows (max 128)
- FIFO_DEPTH, 4, queued character writes (power of two, ≥2)

Ports:
- clk  in  1  system clock (same clock as pixel generator)
- rst  in  1  reset, asynchronous, active-high
- cpu_wr  in  1  write strobe
- cpu_addr  in  2  register select: 0 CURSOR, 1 DATA, 2 CTRL, 3 reserved
- cpu_wdata  in  16  write data
- cpu_rdata  out  16  read data (combinational on cpu_addr)
- cpu_ready  out  1  write will be accepted this cycle
- ram_we  out  1  character RAM write enable (registered)
- ram_addr  out  12  cell index = row*COLS+col (registered)
- ram_wdata  out  11  {colour[2:0], char[7:0]} (registered)

## Operation

- Write is accepted on a rising edge with cpu_wr=1 and cpu_ready=1. When cpu_ready=0, the write is ignored, and the CPU must hold it.
- cpu_ready = !fifo_full && !clear_pending && !clear_active.
- CURSOR write:
  - wdata[14:8]=row, wdata[6:0]=col.
  - If row≥ROWS or col≥COLS, the write is accepted but the cursor is unchanged.
  - Takes effect immediately; it does not affect entries already queued.
- DATA write:
  - Pushes {wdata[10:8], wdata[7:0]} with the current cursor's cell index.
  - Then advances col; at col=COLS-1, col goes to 0 and row increments; at row=ROWS-1, row wraps to 0.
- CTRL write with wdata[0]=1 sets clear_pending; the cursor is set to (0,0) at acceptance. wdata[0]=0 has no effect.
- FSM:
  - IDLE: if FIFO non-empty, pop one entry per cycle and drive the RAM write. Else, if clear_pending, go to CLEAR, clear_pending←0, clear counter←0.
  - CLEAR: write {3'b000, 8'h20} to cell counter every cycle. After cell ROWS*COLS-1, go to IDLE.
- A clear is entered only once the FIFO is empty; queued characters are written first, then overwritten.
- FIFO push and pop in the same cycle are allowed; the count is unchanged.
- cpu_rdata:
  - addr 0: {1'b0, row[6:0], 1'b0, col[6:0]}
  - addr 2: {11'b0, clear_pending|clear_active, fifo_count[3:0]}
  - others: 0

## Timing

- Reset values:
  - ram_we=0, ram_addr=0, ram_wdata=0
  - cpu_ready=1
  - cpu_rdata=0 for addr 0
  - cursor (0,0), FIFO empty, FSM IDLE, clear_pending=0
- DATA write accepted at edge N → ram_we=1 with that entry's address and data from edge N+1 to edge N+2 (one-cycle latency), if FIFO was empty and FSM IDLE.
- Back-to-back writes each cycle sustain one RAM write per cycle; the FIFO never fills in that case.
- Clear occupies exactly ROWS*COLS consecutive ram_we cycles. cpu_ready returns to 1 on the edge that ram_we for the last cell is registered.
- Reset asserted mid-clear or mid-drain: ram_we drops to 0 immediately (asynchronously), the FIFO is flushed, and no further writes occur.
- Cursor readback reflects a CURSOR/DATA write in the cycle after its acceptance edge.

## Configuration

- VGA_TEXT_WRITER_NEWLINE_EN defined:
  - A DATA write with char 8'h0A pushes nothing. It sets col←0 and row←row+1, wrapping ROWS-1→0.
  - It is accepted under the same cpu_ready rule.
- Undefined: 8'h0A is treated as an ordinary glyph (written and cursor advanced).

## Test plan

- Reset, then DATA 16'h0741 → one cycle later ram_we=1, ram_addr=0, ram_wdata=11'h741; cursor reads 16'h0001.
- CURSOR 16'h1D4F (row 29, col 79), then DATA 16'h0142 → ram_addr=2399, ram_wdata=11'h142; cursor reads 16'h0000 (full wrap).
- CURSOR 16'h1E00 (row 30) → cursor unchanged at prior value, no ram_we.
- Hold cpu_wr with cpu_ready stalled by a CTRL clear → DATA writes are ignored while ready=0. Exactly 2400 ram_we cycles occur, addresses 0..2399, data 11'h020. cursor=(0,0) after.
- Push 3 DATA writes, then CTRL clear in consecutive cycles → the 3 characters are written first (addr 0,1,2), then the 2400-cell clear.
- With NEWLINE_EN: cursor (5,10), DATA 16'h000A → no ram_we, cursor reads 16'h0600. Without NEWLINE_EN → ram_wdata=11'h00A at 5*80+10=410.
